// File: rtl/usb_pkg.sv
// Shared USB bit-level definitions used by both the transmit stuffer and the
// receive-side unstuffer.
package usb_pkg;

   localparam int BIT_STUFF_RUN = 6;

   typedef enum logic [1:0] {
      IDLE,
      PASS,
      STUFF
   } bs_state_t;

endpackage

// File: rtl/usb_bit_stuffer_if.sv
// Bit-serial stream between the CRC encoders, the bit stuffer and the NRZI encoder.
// The slave modport is the stuffer; the master modport is whatever drives it.
interface usb_bit_stuffer_if;
   import usb_pkg::*;

   logic in_bit;
   logic in_valid;
   logic in_last;
   logic bs_ready;
   logic out_bit;
   logic out_valid;
   logic out_last;
   logic out_ready;

   modport master (
      output in_bit, in_valid, in_last, out_ready,
      input  bs_ready, out_bit, out_valid, out_last
   );

   modport slave (
      input  in_bit, in_valid, in_last, out_ready,
      output bs_ready, out_bit, out_valid, out_last
   );

endinterface

// File: rtl/usb_bit_stuffer.sv
// USB NRZ bit stuffer: zero-latency pass-through that inserts a 0 after every
// RUN_LEN consecutive 1s, stalling upstream for the stuffed bit.
module usb_bit_stuffer
   import usb_pkg::*;
#(
   parameter int RUN_LEN = BIT_STUFF_RUN,
   parameter int CNT_W   = 3
) (
   input  logic          clock,
   input  logic          reset_n,
   usb_bit_stuffer_if.slave bs
);

   localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(RUN_LEN - 1);

   bs_state_t        state_q, state_d;
   logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
   logic             last_pend_q, last_pend_d;

   logic stuff_needed;
   logic in_xfer;

   assign stuff_needed = bs.in_bit & (run_cnt_q == RUN_MAX);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         run_cnt_q   <= '0;
         last_pend_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         run_cnt_q   <= run_cnt_d;
         last_pend_q <= last_pend_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      run_cnt_d    = run_cnt_q;
      last_pend_d  = last_pend_q;
      bs.out_bit   = bs.in_bit;
      bs.out_valid = bs.in_valid;
      bs.out_last  = bs.in_last & ~stuff_needed;
      bs.bs_ready  = bs.out_ready;
      in_xfer      = bs.in_valid & bs.out_ready;

      unique case (state_q)
         IDLE, PASS: begin
            if (in_xfer) begin
               // A stuff takes priority over in_last so the trailing 0 still goes out.
               if (stuff_needed) begin
                  run_cnt_d   = '0;
                  last_pend_d = bs.in_last;
                  state_d     = STUFF;
               end else if (bs.in_last) begin
                  run_cnt_d = '0;
                  state_d   = IDLE;
               end else if (bs.in_bit) begin
                  run_cnt_d = run_cnt_q + CNT_W'(1);
                  state_d   = PASS;
               end else begin
                  run_cnt_d = '0;
                  state_d   = PASS;
               end
            end
         end
         STUFF: begin
            bs.out_bit   = 1'b0;
            bs.out_valid = 1'b1;
            bs.out_last  = last_pend_q;
            bs.bs_ready  = 1'b0;
            in_xfer      = 1'b0;
            if (bs.out_ready) begin
               last_pend_d = 1'b0;
               state_d     = last_pend_q ? IDLE : PASS;
            end
         end
         default: begin
            state_d   = IDLE;
            run_cnt_d = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_usb_bit_stuffer.sv
// Self-checking bench for usb_bit_stuffer: directed scenarios plus random
// packets compared against a per-bit reference of the stuffing rule.
module tb_usb_bit_stuffer;
   import usb_pkg::*;

   localparam int RUN_LEN = BIT_STUFF_RUN;

   typedef struct packed {
      logic b;
      logic l;
   } exp_t;

   logic clk;
   logic rst_n;
   logic rdy_rand;
   logic forced_rdy;

   int n_checks;
   int n_errors;
   int n_out;
   int n_stuff_obs;
   int model_stuff;
   int ones;
   exp_t exp_q[$];

   usb_bit_stuffer_if bsif();

   usb_bit_stuffer #(.RUN_LEN(RUN_LEN), .CNT_W(3)) dut (
      .clock   (clk),
      .reset_n (rst_n),
      .bs      (bsif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Sole driver of out_ready; updated 2 time units after each rising edge.
   initial begin
      bsif.out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         bsif.out_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : forced_rdy;
      end
   end

   // Output monitor: every output transfer is compared against the expected stream.
   always @(negedge clk) begin
      if (rst_n && bsif.out_valid && bsif.out_ready) begin
         n_out++;
         if (!bsif.bs_ready) n_stuff_obs++;
         if (exp_q.size() == 0) begin
            chk("spurious_out", 32'(bsif.out_valid), 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("out_bit", 32'(bsif.out_bit), 32'(e.b));
            chk("out_last", 32'(bsif.out_last), 32'(e.l));
         end
      end
   end

   // Reference: each accepted 1 extends the run; the RUN_LEN-th 1 is followed by a
   // 0 which inherits the packet-end marker. Packet ends clear the run.
   task automatic model_bit(input logic b, input logic last);
      logic stuff;
      ones  = b ? ones + 1 : 0;
      stuff = (ones == RUN_LEN);
      exp_q.push_back('{b: b, l: last & ~stuff});
      if (stuff) begin
         exp_q.push_back('{b: 1'b0, l: last});
         model_stuff++;
         ones = 0;
      end
      if (last) ones = 0;
   endtask

   task automatic send_bit(input logic b, input logic last);
      bit done;
      model_bit(b, last);
      bsif.in_valid = 1'b1;
      bsif.in_bit   = b;
      bsif.in_last  = last;
      done = 1'b0;
      for (int i = 0; i < 500 && !done; i++) begin
         @(negedge clk);
         if (bsif.bs_ready) done = 1'b1;
         @(posedge clk);
         #1;
      end
      if (!done) chk("in_accept_timeout", 32'd0, 32'd1);
      bsif.in_valid = 1'b0;
      bsif.in_bit   = 1'b0;
      bsif.in_last  = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_ones(input int n, input logic last_on_final);
      for (int i = 0; i < n; i++) send_bit(1'b1, last_on_final && (i == n - 1));
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 400 && exp_q.size() != 0; i++) idle(1);
      chk(tag, 32'(exp_q.size()), 32'd0);
   endtask

   int base_out;
   int base_stuff;

   initial begin
      n_checks = 0; n_errors = 0; n_out = 0; n_stuff_obs = 0; model_stuff = 0; ones = 0;
      rdy_rand = 1'b0; forced_rdy = 1'b1;
      bsif.in_valid = 1'b0; bsif.in_bit = 1'b0; bsif.in_last = 1'b0;
      rst_n = 1'b0;
      idle(3);
      chk("rst_out_valid", 32'(bsif.out_valid), 32'd0);
      chk("rst_out_last", 32'(bsif.out_last), 32'd0);
      chk("rst_bs_ready", 32'(bsif.bs_ready), 32'd1);
      rst_n = 1'b1;
      idle(2);

      // 1: eight 1s, last on the 8th.
      base_out = n_out; base_stuff = n_stuff_obs;
      send_ones(8, 1'b1);
      drain("t1_drain");
      chk("t1_out_count", 32'(n_out - base_out), 32'd9);
      chk("t1_stuff_count", 32'(n_stuff_obs - base_stuff), 32'd1);

      // 2: exactly six 1s ending the packet, then a packet starting with 1.
      base_out = n_out; base_stuff = n_stuff_obs;
      send_ones(6, 1'b1);
      drain("t2a_drain");
      chk("t2a_out_count", 32'(n_out - base_out), 32'd7);
      send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b1);
      drain("t2b_drain");
      chk("t2_out_count", 32'(n_out - base_out), 32'd9);
      chk("t2_stuff_count", 32'(n_stuff_obs - base_stuff), 32'd1);

      // 3: five 1s, a 0, then six 1s with last.
      base_out = n_out; base_stuff = n_stuff_obs;
      send_ones(5, 1'b0);
      send_bit(1'b0, 1'b0);
      send_ones(6, 1'b1);
      drain("t3_drain");
      chk("t3_out_count", 32'(n_out - base_out), 32'd13);
      chk("t3_stuff_count", 32'(n_stuff_obs - base_stuff), 32'd1);

      // 4: run split by an in_valid gap, stall during the stuff bit.
      base_out = n_out; base_stuff = n_stuff_obs;
      send_ones(4, 1'b0);
      idle(5);
      send_bit(1'b1, 1'b0);
      send_bit(1'b1, 1'b1);
      forced_rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t4_stall_valid", 32'(bsif.out_valid), 32'd1);
         chk("t4_stall_bit", 32'(bsif.out_bit), 32'd0);
         chk("t4_stall_last", 32'(bsif.out_last), 32'd1);
         @(posedge clk);
         #1;
      end
      forced_rdy = 1'b1;
      drain("t4_drain");
      chk("t4_out_count", 32'(n_out - base_out), 32'd7);
      chk("t4_stuff_count", 32'(n_stuff_obs - base_stuff), 32'd1);

      // 5: packet A ends in three 1s, packet B starts back-to-back with three 1s.
      base_out = n_out; base_stuff = n_stuff_obs;
      send_ones(3, 1'b1);
      send_ones(3, 1'b0);
      send_bit(1'b0, 1'b1);
      drain("t5_drain");
      chk("t5_out_count", 32'(n_out - base_out), 32'd7);
      chk("t5_stuff_count", 32'(n_stuff_obs - base_stuff), 32'd0);

      // 6: reset while a stuff bit is pending.
      send_ones(6, 1'b0);
      forced_rdy = 1'b0;
      @(negedge clk);
      chk("t6_stuff_valid", 32'(bsif.out_valid), 32'd1);
      chk("t6_stuff_bit", 32'(bsif.out_bit), 32'd0);
      chk("t6_stuff_ready", 32'(bsif.bs_ready), 32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_async_valid", 32'(bsif.out_valid), 32'd0);
      exp_q.delete();
      ones = 0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      forced_rdy = 1'b1;
      model_stuff = n_stuff_obs;
      base_out = n_out; base_stuff = n_stuff_obs;
      send_ones(5, 1'b0);
      send_bit(1'b0, 1'b1);
      drain("t6_drain");
      chk("t6_out_count", 32'(n_out - base_out), 32'd6);
      chk("t6_stuff_count", 32'(n_stuff_obs - base_stuff), 32'd0);

      // Random packets with input gaps and downstream stalls.
      rdy_rand = 1'b1;
      for (int p = 0; p < 40; p++) begin
         int len;
         len = $urandom_range(1, 20);
         for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            send_bit(logic'($urandom_range(0, 4) != 0), logic'(i == len - 1));
         end
         if ($urandom_range(0, 1) == 0) idle($urandom_range(1, 4));
      end
      rdy_rand = 1'b0;
      forced_rdy = 1'b1;
      drain("rand_drain");
      chk("rand_stuff_total", 32'(n_stuff_obs), 32'(model_stuff));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", n_checks, n_errors);
      $fatal(1, "watchdog expired");
   end

endmodule
